// File: rtl/result_writeback_pkg.sv
// result_writeback_pkg: shared widths, FSM encodings and the RELU helper.
package result_writeback_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  function automatic logic [DATA_W-1:0] relu_fn(input logic en, input logic [DATA_W-1:0] d);
    return (en && d[DATA_W-1]) ? '0 : d;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with occupancy count and async active-low reset.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/result_writeback.sv
// result_writeback: buffers allocator results and writes them to memory at offset+index,
// raising done once out_dim*out_dim results are written.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit RELU       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  out_dim,
  input  logic [ADDR_W-1:0] out_memory_offset,
  input  logic              result_ready,
  input  logic [DATA_W-1:0] result_data,
  output logic              result_block,
  input  logic              write_stall,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              overflow,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] state, state_nx;
  logic [ADDR_W-1:0] total, accept_count, write_index;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0] count;
  logic push, pop, empty, full;
  assign total        = {8'd0, out_dim} * {8'd0, out_dim};
  assign full         = count == CW'(FIFO_DEPTH);
  assign result_block = full && state == ST_RUN;
  // accept_count != total keeps a zero-sized layer from accepting anything
  assign push         = result_ready && !full && state == ST_RUN && accept_count != total;
  assign pop          = !empty && !write_stall;
  assign done         = state == ST_DONE;
  result_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (relu_fn(RELU, result_data)),
    .dout  (fifo_dout),
    .empty (empty),
    .count (count)
  );
  always_comb begin
    state_nx = state;
    if (state == ST_RUN && total == '0) state_nx = ST_DONE;
    else if (state == ST_RUN && push && accept_count + 16'd1 == total) state_nx = ST_DRAIN;
    else if (state == ST_DRAIN && empty && write_index == total) state_nx = ST_DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= ST_RUN;
      accept_count <= '0;
      write_index  <= '0;
      write_en     <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      overflow     <= 1'b0;
    end else begin
      state    <= state_nx;
      write_en <= pop;
      if (push) accept_count <= accept_count + 16'd1;
      if (result_ready && state != ST_RUN) overflow <= 1'b1;
      if (pop) begin
        write_data  <= fifo_dout;
        write_addr  <= out_memory_offset + write_index;
        write_index <= write_index + 16'd1;
      end
    end
endmodule
